sq_calc_engine: RTL and testbench

Parametrised stack/queue calculator core for the calculator top level, and the successor to the fixed 32-entry memory controller. It holds operands in a circular buffer that runs as a LIFO (stack) or FIFO (queue), selected per operation. It executes PUSH/POP/ADD/SUB/CLEAR through a valid/ready handshake with a one-cycle done pulse, error and overflow flags. It sits between the debounced button/switch logic and the seven-segment display path.

---
 rtl/sq_calc_pkg.sv | 31 +++
 rtl/sq_ram.sv | 25 ++
 rtl/sq_calc_engine.sv | 216 +++++++++++++++++++++
 tb/tb_sq_calc_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_calc_pkg.sv
// Shared op codes, FSM state encoding and circular-pointer helpers for the
// stack/queue calculator engine.
package sq_calc_pkg;

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_CLEAR = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_WAIT_A,
        S_RD_B,
        S_WAIT_B,
        S_EXEC,
        S_WR,
        S_DONE
    } state_t;

    // Wrap at depth-1 -> 0 so non-power-of-two depths work.
    function automatic logic [31:0] ptr_inc(input logic [31:0] p, input logic [31:0] depth);
        return (p == depth - 32'd1) ? 32'd0 : p + 32'd1;
    endfunction

    function automatic logic [31:0] ptr_dec(input logic [31:0] p, input logic [31:0] depth);
        return (p == 32'd0) ? depth - 32'd1 : p - 32'd1;
    endfunction

endpackage

// File: rtl/sq_ram.sv
// Operand storage: one write port and one synchronous read port, storage
// is deliberately left without reset.
module sq_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sq_calc_engine.sv
// Stack/queue calculator core: circular operand buffer used as LIFO or FIFO
// per op, executing PUSH/POP/ADD/SUB/CLEAR with a one-cycle done pulse.
module sq_calc_engine
    import sq_calc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] din,
    output logic              op_ready,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] peek,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: an op is taken on a rising clk edge where op_valid && op_ready;
    // op, mode and din are captured on that edge and op_ready drops until the
    // cycle after the done pulse.
    state_t             state;
    logic [2:0]         op_r;
    logic               mode_r;
    logic [DATA_W-1:0]  din_r, a_r, b_r, res_r, nxt_r;
    logic               alu_c;
    logic [DATA_W-1:0]  top_val, head_val;
    logic [PTR_W-1:0]   head, tail;
    logic [PTR_W-1:0]   head_p1, head_p2, tail_p1, tail_m1, tail_m2;
    logic [PTR_W-1:0]   raddr, waddr;
    logic [DATA_W-1:0]  rdata, wdata;
    logic               we;
    logic               legal;

    assign head_p1 = PTR_W'(ptr_inc(32'(head), DEPTH));
    assign head_p2 = PTR_W'(ptr_inc(32'(head_p1), DEPTH));
    assign tail_p1 = PTR_W'(ptr_inc(32'(tail), DEPTH));
    assign tail_m1 = PTR_W'(ptr_dec(32'(tail), DEPTH));
    assign tail_m2 = PTR_W'(ptr_dec(32'(tail_m1), DEPTH));

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    // Both ends are tracked so a mode flip is reflected without a RAM read.
    assign peek  = mode ? head_val : top_val;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_PUSH:        legal = !full;
            OP_POP:         legal = !empty;
            OP_ADD, OP_SUB: legal = (count >= CNT_W'(2));
            OP_CLEAR:       legal = 1'b1;
            default:        legal = 1'b0;
        endcase
    end

    // IDLE pre-reads the entry behind the one a POP would remove.
    always_comb begin
        raddr = head;
        case (state)
            S_IDLE:  raddr = mode ? head_p1 : tail_m2;
            S_RD_A:  raddr = mode_r ? head : tail_m1;
            S_RD_B:  raddr = mode_r ? head_p1 : tail_m2;
            S_EXEC:  raddr = head_p2;
            default: raddr = head;
        endcase
    end

    assign we    = (state == S_WR) && !rst;
    assign waddr = (op_r == OP_PUSH || mode_r) ? tail : tail_m2;
    assign wdata = (op_r == OP_PUSH) ? din_r : res_r;

    sq_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
            op_ready <= 1'b1;
            top_val  <= '0;
            head_val <= '0;
            op_r     <= OP_PUSH;
            mode_r   <= 1'b0;
            din_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
            nxt_r    <= '0;
            alu_c    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        op_r     <= op;
                        mode_r   <= mode;
                        din_r    <= din;
                        op_ready <= 1'b0;
                        if (!legal) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            case (op)
                                OP_PUSH: state <= S_WR;
                                OP_CLEAR: begin
                                    head     <= '0;
                                    tail     <= '0;
                                    count    <= '0;
                                    top_val  <= '0;
                                    head_val <= '0;
                                    state    <= S_DONE;
                                    done     <= 1'b1;
                                end
                                default: state <= S_RD_A;
                            endcase
                        end
                    end
                end
                S_RD_A: begin
                    nxt_r <= rdata;
                    state <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    a_r <= rdata;
                    if (op_r == OP_POP) begin
                        result <= rdata;
                        count  <= count - CNT_W'(1);
                        state  <= S_DONE;
                        done   <= 1'b1;
                        if (mode_r) head <= head_p1;
                        else        tail <= tail_m1;
                        if (count == CNT_W'(1)) begin
                            top_val  <= '0;
                            head_val <= '0;
                        end else if (mode_r) begin
                            head_val <= nxt_r;
                        end else begin
                            top_val <= nxt_r;
                        end
                    end else begin
                        state <= S_RD_B;
                    end
                end
                S_RD_B:   state <= S_WAIT_B;
                S_WAIT_B: begin
                    b_r   <= rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    {alu_c, res_r} <= (op_r == OP_ADD) ? {1'b0, b_r} + {1'b0, a_r}
                                                       : {1'b0, b_r} - {1'b0, a_r};
                    state <= S_WR;
                end
                S_WR: begin
                    state   <= S_DONE;
                    done    <= 1'b1;
                    top_val <= (op_r == OP_PUSH) ? din_r : res_r;
                    if (op_r == OP_PUSH) begin
                        tail  <= tail_p1;
                        count <= count + CNT_W'(1);
                        if (count == '0) head_val <= din_r;
                    end else begin
                        result <= res_r;
                        ovf    <= alu_c;
                        count  <= count - CNT_W'(1);
                        if (mode_r) begin
                            head <= head_p2;
                            tail <= tail_p1;
                        end else begin
                            tail <= tail_m1;
                        end
                        // rdata here is the new queue head fetched during EXEC.
                        if (count == CNT_W'(2)) head_val <= res_r;
                        else if (mode_r)        head_val <= rdata;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    ovf      <= 1'b0;
                    op_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sq_calc_engine.sv
// Bench for sq_calc_engine: directed and random ops on a 32-deep and a 5-deep
// instance, checked against a queue-based reference model.
module tb_sq_calc_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [15:0] din = 16'h0;
    logic        sel = 1'b0;

    logic        rdy0, done0, err0, ovf0, empty0, full0;
    logic [15:0] result0, peek0;
    logic [5:0]  count0;
    logic        rdy1, done1, err1, ovf1, empty1, full1;
    logic [15:0] result1, peek1;
    logic [2:0]  count1;

    logic        op_ready_o, done_o, err_o, ovf_o, empty_o, full_o;
    logic [15:0] result_o, peek_o;
    logic [5:0]  count_o;

    logic [15:0] exp_q[$];
    logic [15:0] res_m = 16'h0;
    int          mdl_depth = 32;
    int          n_vec = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sq_calc_engine #(.DATA_W(16), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .mode(mode), .op_valid(op_valid & ~sel), .op(op), .din(din),
        .op_ready(rdy0), .done(done0), .err(err0), .ovf(ovf0), .result(result0),
        .peek(peek0), .count(count0), .empty(empty0), .full(full0)
    );

    sq_calc_engine #(.DATA_W(16), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .mode(mode), .op_valid(op_valid & sel), .op(op), .din(din),
        .op_ready(rdy1), .done(done1), .err(err1), .ovf(ovf1), .result(result1),
        .peek(peek1), .count(count1), .empty(empty1), .full(full1)
    );

    assign op_ready_o = sel ? rdy1 : rdy0;
    assign done_o     = sel ? done1 : done0;
    assign err_o      = sel ? err1 : err0;
    assign ovf_o      = sel ? ovf1 : ovf0;
    assign empty_o    = sel ? empty1 : empty0;
    assign full_o     = sel ? full1 : full0;
    assign result_o   = sel ? result1 : result0;
    assign peek_o     = sel ? peek1 : peek0;
    assign count_o    = sel ? 6'(count1) : count0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic check_state();
        logic [15:0] pk;
        pk = (exp_q.size() == 0) ? 16'h0 : (mode ? exp_q[0] : exp_q[$]);
        chk("count", 32'(count_o), exp_q.size());
        chk("empty", 32'(empty_o), 32'(exp_q.size() == 0));
        chk("full", 32'(full_o), 32'(exp_q.size() == mdl_depth));
        chk("peek", 32'(peek_o), 32'(pk));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        res_m = 16'h0;
    endtask

    task automatic do_op(input logic [2:0] o, input logic m, input logic [15:0] d);
        int          lat, exp_lat;
        logic        ok, exp_err, exp_ovf;
        logic [15:0] a, b;
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        exp_lat = 1;
        case (o)
            3'd0:       ok = exp_q.size() < mdl_depth;
            3'd1:       ok = exp_q.size() > 0;
            3'd2, 3'd3: ok = exp_q.size() >= 2;
            3'd4:       ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        if (!ok) begin
            exp_err = 1'b1;
        end else if (o == 3'd0) begin
            exp_q.push_back(d);
            exp_lat = 2;
        end else if (o == 3'd1) begin
            res_m = m ? exp_q.pop_front() : exp_q.pop_back();
            exp_lat = 3;
        end else if (o == 3'd2 || o == 3'd3) begin
            a = m ? exp_q.pop_front() : exp_q.pop_back();
            b = m ? exp_q.pop_front() : exp_q.pop_back();
            if (o == 3'd2) begin
                res_m = b + a;
                exp_ovf = (int'(b) + int'(a)) > 65535;
            end else begin
                res_m = b - a;
                exp_ovf = (b < a);
            end
            exp_q.push_back(res_m);
            exp_lat = 7;
        end else begin
            exp_q.delete();
        end
        @(negedge clk);
        chk("op_ready", 32'(op_ready_o), 1);
        op_valid = 1'b1;
        op = o;
        mode = m;
        din = d;
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 1;
        while (done_o !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", lat, exp_lat);
        chk("err", 32'(err_o), 32'(exp_err));
        chk("ovf", 32'(ovf_o), 32'(exp_ovf));
        chk("result", 32'(result_o), 32'(res_m));
        check_state();
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done_o), 0);
        chk("err_idle", 32'(err_o | ovf_o), 0);
    endtask

    initial begin
        int   r;
        logic seen_done;

        // reset state
        sel = 1'b0;
        mdl_depth = 32;
        do_reset();
        chk("rst_op_ready", 32'(op_ready_o), 1);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_ovf", 32'(ovf_o), 0);
        chk("rst_result", 32'(result_o), 0);
        check_state();

        // stack fill, overflow attempt and pop
        for (int i = 1; i <= 32; i++) do_op(3'd0, 1'b0, 16'(i));
        chk("fill_full", 32'(full_o), 1);
        do_op(3'd0, 1'b0, 16'd33);
        do_op(3'd1, 1'b0, 16'd0);
        chk("pop_top", 32'(result_o), 32);

        // stack ADD chain down to a single entry
        do_op(3'd0, 1'b0, 16'd32);
        for (int k = 1; k <= 31; k++) do_op(3'd2, 1'b0, 16'd0);
        chk("chain_sum", 32'(result_o), 528);
        chk("chain_count", 32'(count_o), 1);
        do_op(3'd2, 1'b0, 16'd0);

        // queue ordering
        do_op(3'd4, 1'b1, 16'd0);
        do_op(3'd0, 1'b1, 16'd5);
        do_op(3'd0, 1'b1, 16'd7);
        do_op(3'd0, 1'b1, 16'd9);
        do_op(3'd3, 1'b1, 16'd0);
        chk("q_sub", 32'(result_o), 2);
        do_op(3'd1, 1'b1, 16'd0);
        do_op(3'd1, 1'b1, 16'd0);
        chk("q_empty", 32'(empty_o), 1);

        // arithmetic wrap and borrow
        do_op(3'd0, 1'b0, 16'hFFFF);
        do_op(3'd0, 1'b0, 16'h0002);
        do_op(3'd2, 1'b0, 16'd0);
        do_op(3'd0, 1'b0, 16'd3);
        do_op(3'd0, 1'b0, 16'd5);
        do_op(3'd3, 1'b0, 16'd0);
        chk("sub_wrap", 32'(result_o), 32'hFFFE);

        // undefined op code
        do_op(3'b111, 1'b0, 16'd0);

        // random ops against the model
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8)       do_op(3'd0, 1'($urandom_range(0, 1)), 16'($urandom));
            else if (r < 12) do_op(3'd1, 1'($urandom_range(0, 1)), 16'($urandom));
            else if (r < 15) do_op(3'd2, 1'($urandom_range(0, 1)), 16'($urandom));
            else if (r < 18) do_op(3'd3, 1'($urandom_range(0, 1)), 16'($urandom));
            else if (r < 19) do_op(3'd4, 1'($urandom_range(0, 1)), 16'($urandom));
            else             do_op(3'($urandom_range(5, 7)), 1'b0, 16'($urandom));
        end

        // reset while an ADD sits in WAIT_B
        do_op(3'd0, 1'b0, 16'd11);
        do_op(3'd0, 1'b0, 16'd22);
        @(negedge clk);
        op_valid = 1'b1;
        op = 3'd2;
        mode = 1'b0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        res_m = 16'h0;
        chk("rst_mid_ready", 32'(op_ready_o), 1);
        chk("rst_mid_done", 32'(done_o), 0);
        chk("rst_mid_result", 32'(result_o), 0);
        check_state();
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 seen_done = seen_done | done_o;
        end
        chk("rst_mid_no_done", 32'(seen_done), 0);

        // non-power-of-two pointer wrap on the 5-deep instance
        sel = 1'b1;
        mdl_depth = 5;
        do_reset();
        check_state();
        for (int i = 1; i <= 5; i++) do_op(3'd0, 1'b1, 16'(i));
        for (int i = 0; i < 3; i++) do_op(3'd1, 1'b1, 16'd0);
        for (int i = 6; i <= 8; i++) do_op(3'd0, 1'b1, 16'(i));
        chk("d5_full", 32'(full_o), 1);
        @(negedge clk);
        mode = 1'b0;
        #1;
        chk("d5_peek_stack", 32'(peek_o), 8);
        @(negedge clk);
        mode = 1'b1;
        #1;
        chk("d5_peek_queue", 32'(peek_o), 4);
        for (int i = 4; i <= 8; i++) begin
            do_op(3'd1, 1'b1, 16'd0);
            chk("d5_pop", 32'(result_o), i);
        end
        do_op(3'd1, 1'b1, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
